// File: rtl/bcd2bin_seq.sv
// Sequential BCD-to-binary converter: reverse double-dabble, one result bit per clock,
// with start/busy/done handshake and non-decimal digit detection.
module bcd2bin_seq #(
    parameter int unsigned NDIG = 2,
    parameter int unsigned BW   = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [4*NDIG-1:0]   bcd_in,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [BW-1:0]       bin_out
);

    localparam int unsigned DW = 4 * NDIG;
    localparam int unsigned CW = $clog2(BW + 1);
    localparam longint unsigned MAX_DEC = 64'(10 ** NDIG) - 64'd1;
    localparam longint unsigned BIN_LIM = 64'd1 << BW;

    // Largest decimal operand must fit in the binary result.
    if (MAX_DEC >= BIN_LIM) begin : g_bad_params
        $error("bcd2bin_seq: BW too small for NDIG digits");
    end

    // S_DONE is the edge that publishes the result; S_HOLD is the cycle done is visible.
    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE,
        S_HOLD
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [DW-1:0]   r_d, w_d_nxt;
    logic [BW-1:0]   r_b, w_b_nxt;
    logic [CW-1:0]   r_cnt, w_cnt_nxt;
    logic            r_err_pend, w_err_pend_nxt;
    logic            r_busy, w_busy_nxt;
    logic            r_done, w_done_nxt;
    logic            r_err, w_err_nxt;
    logic [BW-1:0]   r_bin, w_bin_nxt;

    logic [DW+BW-1:0] w_cat;
    logic [DW-1:0]    w_sd;
    logic             w_bad;

    // One shift-right step followed by -3 on every digit that is now >= 8.
    always_comb begin
        w_cat = {r_d, r_b} >> 1;
        w_sd  = w_cat[DW+BW-1:BW];
        for (int i = 0; i < int'(NDIG); i++) begin
            if (w_sd[4*i+3]) begin
                w_sd[4*i +: 4] = w_sd[4*i +: 4] - 4'd3;
            end
        end
    end

    always_comb begin
        w_bad = 1'b0;
        for (int i = 0; i < int'(NDIG); i++) begin
            if (bcd_in[4*i +: 4] > 4'd9) begin
                w_bad = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_d_nxt        = r_d;
        w_b_nxt        = r_b;
        w_cnt_nxt      = r_cnt;
        w_err_pend_nxt = r_err_pend;
        w_busy_nxt     = r_busy;
        w_done_nxt     = 1'b0;
        w_err_nxt      = r_err;
        w_bin_nxt      = r_bin;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_d_nxt        = bcd_in;
                    w_b_nxt        = '0;
                    w_cnt_nxt      = CW'(BW);
                    w_busy_nxt     = 1'b1;
                    w_err_pend_nxt = w_bad;
                    w_state_nxt    = w_bad ? S_DONE : S_SHIFT;
                end
            end
            S_SHIFT: begin
                w_d_nxt   = w_sd;
                w_b_nxt   = w_cat[BW-1:0];
                w_cnt_nxt = r_cnt - CW'(1);
                if (r_cnt == CW'(1)) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_done_nxt  = 1'b1;
                w_busy_nxt  = 1'b0;
                w_err_nxt   = r_err_pend;
                w_bin_nxt   = r_err_pend ? '0 : r_b;
                w_state_nxt = S_HOLD;
            end
            S_HOLD: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_d        <= '0;
            r_b        <= '0;
            r_cnt      <= '0;
            r_err_pend <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_bin      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_d        <= w_d_nxt;
            r_b        <= w_b_nxt;
            r_cnt      <= w_cnt_nxt;
            r_err_pend <= w_err_pend_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_err      <= w_err_nxt;
            r_bin      <= w_bin_nxt;
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign err     = r_err;
    assign bin_out = r_bin;

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Directed bench for bcd2bin_seq: default 2-digit instance plus a 3-digit/10-bit instance.
module tb_bcd2bin_seq;

    localparam int unsigned BW  = 8;
    localparam int unsigned BW3 = 10;

    logic            clk;
    logic            rst_n;
    logic            start;
    logic [7:0]      bcd_in;
    logic            busy, done, err;
    logic [BW-1:0]   bin_out;

    logic            start3;
    logic [11:0]     bcd3;
    logic            busy3, done3, err3;
    logic [BW3-1:0]  bin3;

    int errors = 0;
    int checks = 0;

    bcd2bin_seq #(.NDIG(2), .BW(BW)) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .bcd_in  (bcd_in),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .bin_out (bin_out)
    );

    bcd2bin_seq #(.NDIG(3), .BW(BW3)) u_dut3 (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start3),
        .bcd_in  (bcd3),
        .busy    (busy3),
        .done    (done3),
        .err     (err3),
        .bin_out (bin3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Runs one conversion; lat counts edges from the start edge to the one raising done.
    task automatic do_conv(input logic [7:0] v, output logic [7:0] res, output logic e,
                           output int lat, output int bcyc, output logic done_after);
        bcd_in = v;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        bcd_in = ~v;
        lat    = 1;
        bcyc   = 0;
        while (!done && lat < 40) begin
            if (busy) bcyc++;
            tick();
            lat++;
        end
        if (busy) bcyc++;
        res = bin_out;
        e   = err;
        tick();
        done_after = done;
    endtask

    logic [7:0] res;
    logic       e, dn;
    int         lat, bcyc, pulses, n3;
    int         done_edges[$];

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        bcd_in = 8'h00;
        start3 = 1'b0;
        bcd3   = 12'h000;
        tick();
        tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err",  32'(err),  32'd0);
        chk("rst_bin",  32'(bin_out), 32'd0);
        rst_n = 1'b1;
        tick();

        // 1: basic conversion, latency and busy width
        do_conv(8'h42, res, e, lat, bcyc, dn);
        chk("t1_bin",   32'(res), 32'd42);
        chk("t1_err",   32'(e),   32'd0);
        chk("t1_lat",   32'(lat), 32'(BW + 2));
        chk("t1_busy",  32'(bcyc), 32'(BW + 1));
        chk("t1_pulse", 32'(dn),  32'd0);
        chk("t1_hold",  32'(bin_out), 32'd42);

        // 2: extremes and full legal sweep
        do_conv(8'h99, res, e, lat, bcyc, dn);
        chk("t2_99",  32'(res), 32'd99);
        chk("t2_99e", 32'(e),   32'd0);
        do_conv(8'h00, res, e, lat, bcyc, dn);
        chk("t2_00",  32'(res), 32'd0);
        chk("t2_00e", 32'(e),   32'd0);
        for (int t = 0; t < 10; t++) begin
            for (int o = 0; o < 10; o++) begin
                do_conv({4'(t), 4'(o)}, res, e, lat, bcyc, dn);
                chk($sformatf("sweep_%0d%0d", t, o), 32'(res), 32'(t * 10 + o));
                chk($sformatf("sweep_err_%0d%0d", t, o), 32'(e), 32'd0);
            end
        end

        // 3: invalid digit, then recovery
        do_conv(8'hA5, res, e, lat, bcyc, dn);
        chk("t3_lat",  32'(lat), 32'd2);
        chk("t3_err",  32'(e),   32'd1);
        chk("t3_bin",  32'(res), 32'd0);
        chk("t3_busy", 32'(bcyc), 32'd1);
        do_conv(8'h5F, res, e, lat, bcyc, dn);
        chk("t3_lo_err", 32'(e), 32'd1);
        do_conv(8'h07, res, e, lat, bcyc, dn);
        chk("t3_07",  32'(res), 32'd7);
        chk("t3_07e", 32'(e),   32'd0);

        // 4: start held across three conversions, operand disturbed mid-run
        bcd_in = 8'h13;
        start  = 1'b1;
        for (int n = 0; n < 3 * int'(BW + 3); n++) begin
            tick();
            if (n % int'(BW + 3) == 2)      bcd_in = 8'h77;
            if (n % int'(BW + 3) == int'(BW)) bcd_in = 8'h13;
            if (done) begin
                done_edges.push_back(n);
                chk($sformatf("t4_bin_%0d", done_edges.size()), 32'(bin_out), 32'd13);
            end
        end
        start = 1'b0;
        chk("t4_count", 32'(done_edges.size()), 32'd3);
        if (done_edges.size() == 3) begin
            chk("t4_first",  32'(done_edges[0]), 32'(BW + 1));
            chk("t4_space1", 32'(done_edges[1] - done_edges[0]), 32'(BW + 3));
            chk("t4_space2", 32'(done_edges[2] - done_edges[1]), 32'(BW + 3));
        end
        tick();
        tick();

        // 5: reset mid-conversion discards the run
        bcd_in = 8'h42;
        start  = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        chk("t5_busy_pre", 32'(busy), 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_done", 32'(done), 32'd0);
        chk("t5_bin",  32'(bin_out), 32'd0);
        pulses = 0;
        repeat (15) begin
            tick();
            if (done) pulses++;
        end
        chk("t5_nopulse", 32'(pulses), 32'd0);
        chk("t5_bin_idle", 32'(bin_out), 32'd0);
        do_conv(8'h56, res, e, lat, bcyc, dn);
        chk("t5_56",  32'(res), 32'd56);
        chk("t5_56e", 32'(e),   32'd0);

        // 6: three-digit instance
        bcd3   = 12'h999;
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        bcd3   = 12'h000;
        n3 = 1;
        while (!done3 && n3 < 40) begin
            tick();
            n3++;
        end
        chk("t6_lat", 32'(n3),   32'(BW3 + 2));
        chk("t6_bin", 32'(bin3), 32'd999);
        chk("t6_err", 32'(err3), 32'd0);
        tick();
        tick();
        bcd3   = 12'h9B0;
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        tick();
        chk("t6_bad_done", 32'(done3), 32'd1);
        chk("t6_bad_err",  32'(err3),  32'd1);
        chk("t6_bad_bin",  32'(bin3),  32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
